debug_loader: RTL

- UART-driven program loader sitting directly upstream of the core top level.
- Produces the debug_i / debug_addr_i / debug_data_i / debug_imem_i / debug_full_reset_i inputs that the top level uses to write instruction and data memory.
- Receives an 8N1 serial byte stream and decodes a small framed command protocol into one-cycle byte-write strobes.
- Holds the core in reset while a load session is open.

---
 rtl/debug_pkg.sv | 14 +
 rtl/uart_rx.sv | 131 +++++++++++++
 rtl/debug_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared protocol constants and state encodings for the UART debug loader.
package debug_pkg;

  localparam logic [7:0] SyncByte = 8'hA5;
  localparam logic [7:0] CmdLoad  = 8'h01;
  localparam logic [7:0] CmdRun   = 8'h02;
  localparam logic [7:0] CmdClear = 8'h03;

  localparam int DMemBase = 4096;

  typedef enum logic [2:0] {IDLE, CMD, A0, A1, L0, L1, DATA} loader_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_i, samples mid-bit, and emits one-cycle
// valid or framing-error pulses.
module uart_rx
  import debug_pkg::*;
#(
  parameter int ClksPerBit = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing and framing; a start bit that is high again at mid-bit is a glitch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (!rx_sync_q) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/debug_loader.sv
// UART program loader: decodes sync/cmd frames into byte-write strobes for the
// core's debug memory port and holds the core in reset while a session is open.
module debug_loader
  import debug_pkg::*;
#(
  parameter int ClksPerBit    = 868,
  parameter int AddrWidth     = 13,
  parameter int TimeoutCycles = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic                 debug_o,
  output logic [AddrWidth-1:0] debug_addr_o,
  output logic [7:0]           debug_data_o,
  output logic                 debug_imem_o,
  output logic                 debug_full_reset_o,
  output logic                 core_hold_o,
  output logic                 err_o
);

  localparam int TmoW = $clog2(TimeoutCycles + 1);

  logic [7:0] rx_data_s;
  logic       rx_valid_s;
  logic       rx_ferr_s;
  logic       timeout_s;

  loader_state_t        state_q, state_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d;
  logic [7:0]           addr_lo_q, addr_lo_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 debug_q, debug_d;
  logic [AddrWidth-1:0] daddr_q, daddr_d;
  logic [7:0]           ddata_q, ddata_d;
  logic                 dimem_q, dimem_d;
  logic                 fr_q, fr_d;
  logic                 hold_q, hold_d;
  logic                 err_q, err_d;

  uart_rx #(.ClksPerBit(ClksPerBit)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_i),
    .data_o     (rx_data_s),
    .valid_o    (rx_valid_s),
    .frame_err_o(rx_ferr_s)
  );

  // Loader state, write pointer, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      addr_lo_q <= 8'h00;
      cnt_q     <= 16'h0000;
      tmo_q     <= '0;
      debug_q   <= 1'b0;
      daddr_q   <= '0;
      ddata_q   <= 8'h00;
      dimem_q   <= 1'b0;
      fr_q      <= 1'b0;
      hold_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      addr_lo_q <= addr_lo_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      debug_q   <= debug_d;
      daddr_q   <= daddr_d;
      ddata_q   <= ddata_d;
      dimem_q   <= dimem_d;
      fr_q      <= fr_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
    end
  end

  // A byte arriving in the same cycle as expiry wins over the timeout.
  assign timeout_s = (state_q != IDLE) && (tmo_q == TmoW'(TimeoutCycles - 1)) && !rx_valid_s;

  // Protocol decode, write strobe generation and timeout handling.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    addr_lo_d = addr_lo_q;
    cnt_d     = cnt_q;
    daddr_d   = daddr_q;
    ddata_d   = ddata_q;
    dimem_d   = dimem_q;
    hold_d    = hold_q;
    debug_d   = 1'b0;
    fr_d      = 1'b0;
    err_d     = err_q | rx_ferr_s;

    if (state_q == IDLE || rx_valid_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (timeout_s) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (rx_valid_s) begin
      case (state_q)
        IDLE: begin
          if (rx_data_s == SyncByte) begin
            err_d   = 1'b0;
            state_d = CMD;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          case (rx_data_s)
            CmdLoad: begin
              hold_d  = 1'b1;
              state_d = A0;
            end
            CmdRun: begin
              hold_d  = 1'b0;
              state_d = IDLE;
            end
            CmdClear: begin
              fr_d    = 1'b1;
              hold_d  = 1'b1;
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        A0: begin
          addr_lo_d = rx_data_s;
          state_d   = A1;
        end
        A1: begin
          waddr_d = AddrWidth'({rx_data_s, addr_lo_q});
          state_d = L0;
        end
        L0: begin
          cnt_d   = {8'h00, rx_data_s};
          state_d = L1;
        end
        L1: begin
          cnt_d = {rx_data_s, cnt_q[7:0]};
          if ({rx_data_s, cnt_q[7:0]} == 16'h0000) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          debug_d = 1'b1;
          daddr_d = waddr_q;
          ddata_d = rx_data_s;
          dimem_d = (32'(waddr_q) < 32'(DMemBase));
          waddr_d = waddr_q + AddrWidth'(1);
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign debug_o            = debug_q;
  assign debug_addr_o       = daddr_q;
  assign debug_data_o       = ddata_q;
  assign debug_imem_o       = dimem_q;
  assign debug_full_reset_o = fr_q;
  assign core_hold_o        = hold_q;
  assign err_o              = err_q;

endmodule
